// File: rtl/vga_timing_pkg.sv
// Nominal 640x480 VGA timing, derived window starts and decoder state encoding.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE    = 640;
  localparam int unsigned VGA_H_SYNC      = 96;
  localparam int unsigned VGA_H_BP        = 48;
  localparam int unsigned VGA_H_TOTAL     = 800;
  localparam int unsigned VGA_V_ACTIVE    = 480;
  localparam int unsigned VGA_V_SYNC      = 2;
  localparam int unsigned VGA_V_BP        = 33;
  localparam int unsigned VGA_V_TOTAL     = 525;
  localparam int unsigned VGA_LOCK_FRAMES = 2;

  localparam int unsigned VGA_H_START = VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_START = VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } dec_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Samples an active-low sync on pix_en and flags its falling edge combinationally.
// Latency: fall_o is valid in the pix_en cycle that sees the low input; no backpressure.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic pix_en_i,
  input  logic sync_i,
  output logic fall_o
);

  logic sync_q;

  // Idle-high reset value so a sync that is already low counts as a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b1;
    end else if (pix_en_i) begin
      sync_q <= sync_i;
    end
  end

  assign fall_o = pix_en_i && sync_q && !sync_i;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, video_on and timing lock from active-low hsync/vsync.
// Outputs lag the sync inputs by one pix_en edge; no backpressure. VGA_DEC_ERRCNT_EN adds err_count.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BP        = VGA_H_BP,
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BP        = VGA_V_BP,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
  parameter int unsigned LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
`ifdef VGA_DEC_ERRCNT_EN
  output logic [7:0] err_count,
`endif
  output logic       locked
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);

  localparam logic [9:0]    CNT_MAX   = 10'd1023;
  localparam logic [9:0]    H_START_C = 10'(H_SYNC + H_BP);
  localparam logic [9:0]    H_END_C   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]    V_START_C = 10'(V_SYNC + V_BP);
  localparam logic [9:0]    V_END_C   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0]   H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0]   V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [GW-1:0] LOCK_C    = GW'(LOCK_FRAMES);

  logic          hs_fall, vs_fall;
  logic [9:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [10:0]   vcnt_eff;
  logic          h_seen_q, v_seen_q;
  logic          line_err_q, line_err_d;
  logic [GW-1:0] good_q, good_d;
  dec_state_e    state_q, state_d;
  logic          hcnt_sat, line_bad, frame_chk, frame_bad, in_win;

  sync_edge_det u_hs_edge (
    .clk      (clk),
    .reset    (reset),
    .pix_en_i (pix_en),
    .sync_i   (hsync_in),
    .fall_o   (hs_fall)
  );

  sync_edge_det u_vs_edge (
    .clk      (clk),
    .reset    (reset),
    .pix_en_i (pix_en),
    .sync_i   (vsync_in),
    .fall_o   (vs_fall)
  );

  // A line that ends on the frame's closing vsync fall still belongs to that frame.
  always_comb begin
    hcnt_sat  = (hcnt_q == CNT_MAX);
    vcnt_eff  = {1'b0, vcnt_q} + {10'd0, hs_fall};
    line_bad  = hs_fall && h_seen_q && (({1'b0, hcnt_q} + 11'd1) != H_TOTAL_C);
    frame_chk = vs_fall && v_seen_q;
    frame_bad = frame_chk && ((vcnt_eff != V_TOTAL_C) || line_err_q || line_bad);
  end

  always_comb begin
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    line_err_d = line_err_q;
    if (pix_en) begin
      if (hs_fall) begin
        hcnt_d = '0;
      end else if (!hcnt_sat) begin
        hcnt_d = hcnt_q + 10'd1;
      end
      if (vs_fall) begin
        vcnt_d = '0;
      end else if (hs_fall && (vcnt_q != CNT_MAX)) begin
        vcnt_d = vcnt_q + 10'd1;
      end
      if (vs_fall) begin
        line_err_d = 1'b0;
      end else if (line_bad) begin
        line_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (pix_en) begin
      unique case (state_q)
        SEARCH: begin
          if (vs_fall) begin
            state_d = MEASURE;
            good_d  = '0;
          end
        end
        MEASURE: begin
          if (hcnt_sat) begin
            state_d = SEARCH;
            good_d  = '0;
          end else if (frame_bad) begin
            good_d = '0;
          end else if (frame_chk) begin
            good_d = good_q + GW'(1);
            if ((good_q + GW'(1)) == LOCK_C) begin
              state_d = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (line_bad || frame_bad || hcnt_sat) begin
            state_d = SEARCH;
            good_d  = '0;
          end
        end
        default: begin
          state_d = SEARCH;
          good_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      h_seen_q   <= 1'b0;
      v_seen_q   <= 1'b0;
      line_err_q <= 1'b0;
      good_q     <= '0;
      state_q    <= SEARCH;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      line_err_q <= line_err_d;
      good_q     <= good_d;
      state_q    <= state_d;
      if (hs_fall) h_seen_q <= 1'b1;
      if (vs_fall) v_seen_q <= 1'b1;
    end
  end

`ifdef VGA_DEC_ERRCNT_EN
  logic [7:0] err_q;

  // A bad line and a bad frame on the same edge count as one error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else if ((line_bad || frame_bad) && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`endif

  always_comb begin
    in_win   = (hcnt_q >= H_START_C) && (hcnt_q < H_END_C) &&
               (vcnt_q >= V_START_C) && (vcnt_q < V_END_C);
    locked   = (state_q == LOCKED);
    video_on = locked && in_win;
    pixel_x  = video_on ? (hcnt_q - H_START_C) : '0;
    pixel_y  = video_on ? (vcnt_q - V_START_C) : '0;
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down 28x16 raster; an event-level model of line/frame
// periods predicts every output each clk, with literal checks at lock and window boundaries.
module tb_vga_sync_decoder;

  localparam int HA = 16, HS = 4, HB = 4, HT = 28;
  localparam int VA = 8,  VS = 2, VB = 3, VT = 16;
  localparam int LF = 2;
  localparam int HST = HS + HB;
  localparam int VST = VS + VB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, locked;
`ifdef VGA_DEC_ERRCNT_EN
  logic [7:0] err_count;
`endif

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pix_en   (pix_en),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .video_on (video_on),
`ifdef VGA_DEC_ERRCNT_EN
    .err_count(err_count),
`endif
    .locked   (locked)
  );

  int n_chk = 0;
  int n_fail = 0;
  int ratio = 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: positions are measured as distances from the last sync falls,
  // lock as a count of consecutive frames with the right period.
  int m_pe, m_hf_at, m_lines, m_mode, m_good, m_errc;
  bit m_phs, m_pvs, m_sh, m_sv, m_ferr;

  task automatic model_reset();
    m_pe = 0; m_hf_at = 0; m_lines = 0; m_mode = 0; m_good = 0; m_errc = 0;
    m_phs = 1; m_pvs = 1; m_sh = 0; m_sv = 0; m_ferr = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs);
    bit hf, vf, bad_line, fchk, fbad, sat;
    int len, nlines;
    hf = m_phs && !hs;
    vf = m_pvs && !vs;
    m_phs = hs;
    m_pvs = vs;
    len      = m_pe - m_hf_at + 1;
    sat      = (m_pe - m_hf_at) >= 1023;
    nlines   = m_lines + (hf ? 1 : 0);
    bad_line = hf && m_sh && (len != HT);
    fchk     = vf && m_sv;
    fbad     = fchk && (nlines != VT || m_ferr || bad_line);
    m_pe++;
    if (hf) m_hf_at = m_pe;
    if (vf) m_lines = 0; else if (hf) m_lines++;
    if (vf) m_ferr = 0; else if (bad_line) m_ferr = 1;
    case (m_mode)
      0: if (vf) begin m_mode = 1; m_good = 0; end
      1: begin
        if (sat) m_mode = 0;
        else if (fbad) m_good = 0;
        else if (fchk) begin
          m_good++;
          if (m_good == LF) m_mode = 2;
        end
      end
      default: if (bad_line || fbad || sat) m_mode = 0;
    endcase
    if ((bad_line || fbad) && m_errc < 255) m_errc++;
    if (hf) m_sh = 1;
    if (vf) m_sv = 1;
  endtask

  task automatic compare();
    int hc, vc;
    bit win, lk, vo;
    hc  = (m_pe - m_hf_at > 1023) ? 1023 : (m_pe - m_hf_at);
    vc  = (m_lines > 1023) ? 1023 : m_lines;
    win = (hc >= HST) && (hc < HST + HA) && (vc >= VST) && (vc < VST + VA);
    lk  = (m_mode == 2);
    vo  = lk && win;
    chk("locked", int'(locked), int'(lk));
    chk("video_on", int'(video_on), int'(vo));
    chk("pixel_x", int'(pixel_x), vo ? hc - HST : 0);
    chk("pixel_y", int'(pixel_y), vo ? vc - VST : 0);
`ifdef VGA_DEC_ERRCNT_EN
    chk("err_count", int'(err_count), m_errc);
`endif
  endtask

  task automatic step(input bit hs, input bit vs);
    for (int k = 0; k < ratio; k++) begin
      @(negedge clk);
      hsync_in = hs;
      vsync_in = vs;
      pix_en   = (k == ratio - 1);
      @(posedge clk);
      if (pix_en) model_step(hs, vs);
      #1;
      compare();
    end
  endtask

  task automatic pix(input int l, input int p);
    step((p < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1);
  endtask

  task automatic send_line(input int l, input int len);
    for (int p = 0; p < len; p++) pix(l, p);
  endtask

  task automatic lines_from(input int l0);
    for (int l = l0; l < VT; l++) send_line(l, HT);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    pix_en = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_video_on", int'(video_on), 0);
    chk("rst_pixel_x", int'(pixel_x), 0);
    chk("rst_pixel_y", int'(pixel_y), 0);
`ifdef VGA_DEC_ERRCNT_EN
    chk("rst_err_count", int'(err_count), 0);
`endif
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    apply_reset();

    // Ideal timing: lock on the third vsync fall, window edges.
    lines_from(0);
    lines_from(0);
    chk("t1_unlocked_before_3rd_vfall", int'(locked), 0);
    pix(0, 0);
    chk("t1_locked_at_3rd_vfall", int'(locked), 1);
    for (int p = 1; p < HT; p++) pix(0, p);
    for (int l = 1; l < VST; l++) send_line(l, HT);
    for (int p = 0; p < HT; p++) begin
      pix(VST, p);
      if (p == HST - 1) chk("t1_vo_before_window", int'(video_on), 0);
      if (p == HST) begin
        chk("t1_first_px", int'(pixel_x), 0);
        chk("t1_first_py", int'(pixel_y), 0);
        chk("t1_first_vo", int'(video_on), 1);
      end
      if (p == HST + HA - 1) chk("t1_last_px", int'(pixel_x), HA - 1);
      if (p == HST + HA) chk("t1_vo_after_window", int'(video_on), 0);
    end

    // One over-long line drops lock; two further good frames relock.
    send_line(VST + 1, HT + 1);
    pix(VST + 2, 0);
    chk("t2_unlock_after_long_line", int'(locked), 0);
    for (int p = 1; p < HT; p++) pix(VST + 2, p);
    lines_from(VST + 3);
    lines_from(0);
    lines_from(0);
    chk("t2_unlocked_before_relock", int'(locked), 0);
    pix(0, 0);
    chk("t2_relocked", int'(locked), 1);

    // hsync stuck high: counter saturates and lock is lost.
    for (int p = 1; p < HT; p++) pix(0, p);
    for (int l = 1; l < 4; l++) send_line(l, HT);
    for (int i = 0; i < 1100; i++) step(1'b1, 1'b1);
    chk("t3_unlocked_stuck_hsync", int'(locked), 0);
    chk("t3_video_off_stuck_hsync", int'(video_on), 0);

    // Relock, then reset mid-frame.
    lines_from(0);
    lines_from(0);
    pix(0, 0);
    chk("t4_locked_before_reset", int'(locked), 1);
    for (int p = 1; p < HT; p++) pix(0, p);
    for (int l = 1; l < 10; l++) send_line(l, HT);
    for (int p = 0; p <= 12; p++) pix(10, p);
    chk("t4_vo_mid_frame", int'(video_on), 1);
    chk("t4_px_mid_frame", int'(pixel_x), 4);
    chk("t4_py_mid_frame", int'(pixel_y), 5);
    apply_reset();
    for (int p = 13; p < HT; p++) pix(10, p);
    lines_from(11);
    lines_from(0);
    lines_from(0);
    chk("t4_unlocked_2nd_vfall", int'(locked), 0);
    pix(0, 0);
    chk("t4_relocked_3rd_vfall", int'(locked), 1);

    // pix_en one clk in four.
    apply_reset();
    ratio = 4;
    lines_from(0);
    lines_from(0);
    chk("t5_unlocked_before_3rd", int'(locked), 0);
    pix(0, 0);
    chk("t5_locked_3rd_vfall", int'(locked), 1);
    for (int p = 1; p < HT; p++) pix(0, p);
    for (int l = 1; l < VST; l++) send_line(l, HT);
    for (int p = 0; p <= HST + 3; p++) pix(VST, p);
    chk("t5_px", int'(pixel_x), 3);
    chk("t5_py", int'(pixel_y), 0);
    chk("t5_vo", int'(video_on), 1);
    ratio = 1;

`ifdef VGA_DEC_ERRCNT_EN
    // Short lines saturate the error counter; reset clears it.
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      send_line(VS, HT - 1);
      if (n == 9) chk("t6_err_after_10_lines", int'(err_count), 9);
    end
    chk("t6_err_saturated", int'(err_count), 255);
    apply_reset();
    chk("t6_err_cleared", int'(err_count), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
